// File: rtl/addr_trace_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : addr_trace_if                                               |
// | Purpose : Bus between addr_trace and the downstream hex-line sender.  |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
interface addr_trace_if;
  logic [19:0] wbm_dat_o;
  logic        wbm_we_o;
  logic        wbm_stb_o;
  logic        wbm_cyc_o;
  logic        wbm_ack_i;

  modport master (
    output wbm_dat_o,
    output wbm_we_o,
    output wbm_stb_o,
    output wbm_cyc_o,
    input  wbm_ack_i
  );

  modport slave (
    input  wbm_dat_o,
    input  wbm_we_o,
    input  wbm_stb_o,
    input  wbm_cyc_o,
    output wbm_ack_i
  );
endinterface
`default_nettype wire

// File: rtl/addr_trace.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : addr_trace                                                  |
// | Purpose : Captures strobed addresses into a FIFO and emits them one   |
// |           word per bus cycle. Define TRACE_DEDUP_EN to suppress       |
// |           captures equal to the last pushed address.                  |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module addr_trace #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_,
  input  logic         trace_en,
  input  logic         trace_stb,
  input  logic [19:0]  trace_addr,
  addr_trace_if.master wbm,
  output logic [7:0]   drop_cnt,
  output logic         fifo_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic [19:0]     fifo_mem [DEPTH];

  logic            full;
  logic            empty;
  logic            pop;
  logic            capture;
  logic            push;
  logic            drop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
  assign pop   = (state_q == ST_REQ) && wbm.wbm_ack_i;

`ifdef TRACE_DEDUP_EN
  logic [19:0] last_addr_q, last_addr_d;
  logic        last_vld_q, last_vld_d;

  // The valid flag lets a first capture of address zero through.
  assign capture = trace_en && trace_stb &&
                   !(last_vld_q && (trace_addr == last_addr_q));

  always_comb begin
    last_addr_d = last_addr_q;
    last_vld_d  = last_vld_q;
    if (push) begin
      last_addr_d = trace_addr;
      last_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_) begin
    if (!wb_rst_) begin
      last_addr_q <= 20'h0;
      last_vld_q  <= 1'b0;
    end else begin
      last_addr_q <= last_addr_d;
      last_vld_q  <= last_vld_d;
    end
  end
`else
  assign capture = trace_en && trace_stb;
`endif

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push = capture && (!full || pop);
  assign drop = capture && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    drop_cnt_d = drop_cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!empty) state_d = ST_REQ;
      ST_REQ:  if (wbm.wbm_ack_i) state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_) begin
    if (!wb_rst_) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drop_cnt_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q[PW-2:0]] <= trace_addr;
    end
  end

  // Outputs decode the registered state so reset removes them at once.
  assign wbm.wbm_stb_o = (state_q == ST_REQ);
  assign wbm.wbm_cyc_o = (state_q == ST_REQ);
  assign wbm.wbm_we_o  = (state_q == ST_REQ);
  assign wbm.wbm_dat_o = (state_q == ST_REQ) ? fifo_mem[rd_ptr_q[PW-2:0]] : 20'h0;

  assign drop_cnt   = drop_cnt_q;
  assign fifo_empty = empty;

endmodule
`default_nettype wire

// File: tb/tb_addr_trace.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_addr_trace                                               |
// | Purpose : Scoreboard bench for addr_trace (directed + random).        |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module tb_addr_trace;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        trace_en = 1'b0;
  logic        trace_stb = 1'b0;
  logic [19:0] trace_addr = 20'h0;
  logic [7:0]  drop_cnt;
  logic        fifo_empty;

  int          ack_mode = 3;
  logic        ack_manual = 1'b0;
  logic        ack_auto = 1'b0;

  int          n_checks = 0;
  int          n_fail = 0;

  logic [19:0] q[$];
  int          m_drop = 0;
  logic [19:0] m_last = 20'h0;
  bit          m_last_vld = 1'b0;
  int          words_out = 0;
  bit          prev_pop = 1'b0;
  int          low_run = 0;

  addr_trace_if wbm();

  assign wbm.wbm_ack_i = (ack_mode == 3) ? ack_manual : ack_auto;

  addr_trace #(.DEPTH_LOG2(4)) dut (
    .wb_clk_i   (clk),
    .wb_rst_    (rst_n),
    .trace_en   (trace_en),
    .trace_stb  (trace_stb),
    .trace_addr (trace_addr),
    .wbm        (wbm),
    .drop_cnt   (drop_cnt),
    .fifo_empty (fifo_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream responder: 0 never, 1 always, 2 random, 3 manual.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        1:       ack_auto = 1'b1;
        2:       ack_auto = ($urandom_range(0, 1) == 1);
        default: ack_auto = 1'b0;
      endcase
    end
  end

  // Monitor + reference model. Inputs and outputs are stable from the
  // falling edge until the next rising edge, so the values seen here
  // describe exactly what the next rising edge will act on.
  initial begin
    bit pop;
    bit req;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        m_drop     = 0;
        m_last_vld = 1'b0;
        prev_pop   = 1'b0;
        low_run    = 0;
      end
      check("cyc_eq_stb", wbm.wbm_cyc_o, wbm.wbm_stb_o);
      check("we_eq_stb", wbm.wbm_we_o, wbm.wbm_stb_o);
      check("fifo_empty", fifo_empty, (q.size() == 0));
      check("drop_cnt", drop_cnt, m_drop);
      check("stb_has_data", wbm.wbm_stb_o, (wbm.wbm_stb_o && q.size() > 0));
      if (wbm.wbm_stb_o && q.size() > 0)
        check("head_dat", wbm.wbm_dat_o, q[0]);
      else if (!wbm.wbm_stb_o)
        check("idle_dat", wbm.wbm_dat_o, 20'h0);
      if (prev_pop)
        check("gap_after_ack", wbm.wbm_stb_o, 1'b0);
      if (!wbm.wbm_stb_o && q.size() > 0) low_run++;
      else low_run = 0;
      check("stb_latency", (low_run <= 2), 1'b1);

      pop = 1'b0;
      if (rst_n) begin
        pop = wbm.wbm_stb_o && wbm.wbm_ack_i;
        if (pop) begin
          void'(q.pop_front());
          words_out++;
        end
        req = trace_en && trace_stb;
`ifdef TRACE_DEDUP_EN
        if (m_last_vld && trace_addr == m_last) req = 1'b0;
`endif
        if (req) begin
          if (q.size() < 16) begin
            q.push_back(trace_addr);
            m_last     = trace_addr;
            m_last_vld = 1'b1;
          end else if (m_drop < 255) begin
            m_drop++;
          end
        end
      end
      prev_pop = pop;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [19:0] a);
    trace_en   = 1'b1;
    trace_stb  = 1'b1;
    trace_addr = a;
    tick();
    trace_stb  = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q.size() != 0 || !fifo_empty || wbm.wbm_stb_o) && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", (n < budget), 1'b1);
  endtask

  initial begin
    int w0;
    int exp_words;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_stb", wbm.wbm_stb_o, 1'b0);
    check("rst_cyc", wbm.wbm_cyc_o, 1'b0);
    check("rst_dat", wbm.wbm_dat_o, 20'h0);
    check("rst_empty", fifo_empty, 1'b1);
    check("rst_drop", drop_cnt, 8'h00);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Single word, slow acknowledge.
    ack_mode = 3; ack_manual = 1'b0;
    trace_en = 1'b1; trace_stb = 1'b1; trace_addr = 20'hABCDE;
    tick();
    trace_stb = 1'b0;
    check("lat_idle_stb", wbm.wbm_stb_o, 1'b0);
    check("lat_not_empty", fifo_empty, 1'b0);
    tick();
    check("lat_stb", wbm.wbm_stb_o, 1'b1);
    check("lat_dat", wbm.wbm_dat_o, 20'hABCDE);
    repeat (59) tick();
    check("hold_dat", wbm.wbm_dat_o, 20'hABCDE);
    ack_manual = 1'b1;
    tick();
    ack_manual = 1'b0;
    check("gap_stb", wbm.wbm_stb_o, 1'b0);
    check("gap_empty", fifo_empty, 1'b1);
    tick();
    check("idle_stb", wbm.wbm_stb_o, 1'b0);

    // Fill, overflow by three, then drain in order.
    for (int i = 0; i < 16; i++) strobe(20'h10000 + 20'(i * 16));
    for (int i = 0; i < 3; i++) strobe(20'h20000 + 20'(i));
    check("overflow_drop", drop_cnt, 8'd3);
    w0 = words_out;
    ack_mode = 1;
    drain(200);
    check("drain16_words", words_out - w0, 16);
    check("drain16_drop", drop_cnt, 8'd3);

    // Push coinciding with pop while full.
    ack_mode = 3; ack_manual = 1'b0;
    for (int i = 0; i < 16; i++) strobe(20'h30000 + 20'(i));
    tick(); tick();
    check("full_req_stb", wbm.wbm_stb_o, 1'b1);
    trace_stb = 1'b1; trace_addr = 20'h3ABCD; ack_manual = 1'b1;
    tick();
    trace_stb = 1'b0; ack_manual = 1'b0;
    check("simul_drop", drop_cnt, 8'd3);
    strobe(20'h3BEEF);
    check("still_full_drop", drop_cnt, 8'd4);

    // Saturation.
    for (int i = 0; i < 300; i++) strobe(20'h40000 + 20'(i));
    check("sat_drop", drop_cnt, 8'hFF);

    // Asynchronous reset in the middle of a request.
    tick();
    check("pre_rst_stb", wbm.wbm_stb_o, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_stb", wbm.wbm_stb_o, 1'b0);
    check("mid_rst_cyc", wbm.wbm_cyc_o, 1'b0);
    check("mid_rst_empty", fifo_empty, 1'b1);
    check("mid_rst_drop", drop_cnt, 8'h00);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Duplicate suppression.
    ack_mode = 1;
    w0 = words_out;
    strobe(20'h00100);
    strobe(20'h00100);
    strobe(20'h00104);
    drain(100);
`ifdef TRACE_DEDUP_EN
    exp_words = 2;
`else
    exp_words = 3;
`endif
    check("dedup_words", words_out - w0, exp_words);

    // Random traffic with alternating stall and random-acknowledge windows.
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) ack_mode = ((c / 200) % 3 == 1) ? 0 : 2;
      trace_en   = ($urandom_range(0, 3) != 0);
      trace_stb  = ($urandom_range(0, 2) == 0);
      trace_addr = 20'($urandom_range(0, 7) * 4);
      tick();
    end
    trace_stb = 1'b0;
    ack_mode = 1;
    drain(500);
    check("final_drop", drop_cnt, m_drop);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/addr_trace.md
ADDR_TRACE -- requirements
Module: addr_trace

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, log2 of capture FIFO depth (16 entries).
REQ-002 SHALL have port wb_clk_i  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port wb_rst_  input  1  reset; the block has one clock, and reset is asynchronous and active-low.
REQ-004 SHALL have port trace_en  input  1  capture enable; when low, strobes are ignored (not counted as drops).
REQ-005 SHALL have port trace_stb  input  1  single-cycle sample strobe.
REQ-006 SHALL have port trace_addr  input  20  address sampled when trace_stb is high.
REQ-007 SHALL have port wbm_dat_o  output  20  FIFO head address, driven to the downstream hex-line sender.
REQ-008 SHALL have port wbm_we_o  output  1  write enable; equal to wbm_stb_o.
REQ-009 SHALL have port wbm_stb_o  output  1  strobe.
REQ-010 SHALL have port wbm_cyc_o  output  1  cycle; equal to wbm_stb_o.
REQ-011 SHALL have port wbm_ack_i  input  1  downstream acknowledge; it arrives after the full line has been transmitted.
REQ-012 SHALL have port drop_cnt  output  8  saturating count of captures lost to a full FIFO.
REQ-013 SHALL have port fifo_empty  output  1  high when the FIFO holds 0 entries.

Function
REQ-014 SHALL push trace_addr on a cycle with trace_en & trace_stb when the FIFO is not full or a pop occurs in the same cycle.
REQ-015 SHALL discard the capture when the FIFO is full with no simultaneous pop, and increment drop_cnt, saturating at 8'hFF.
REQ-016 SHALL use 2^DEPTH_LOG2 entries, with read and write pointers DEPTH_LOG2+1 bits wide that wrap modulo 2^(DEPTH_LOG2+1); full/empty SHALL be derived from pointer MSB/LSB compare.
REQ-017 SHALL implement master FSM IDLE -> REQ -> GAP -> IDLE.
REQ-018 In IDLE with FIFO non-empty, the FSM SHALL go to REQ on the next edge.
REQ-019 In REQ, wbm_stb_o, wbm_cyc_o and wbm_we_o SHALL be high and wbm_dat_o SHALL be the FIFO head, stable until ack.
REQ-020 In REQ with wbm_ack_i high, the FSM SHALL pop the head and go to GAP.
REQ-021 GAP SHALL hold stb/cyc low for exactly one cycle, then go to IDLE, so the downstream sender re-arms before the next word.
REQ-022 SHALL ignore wbm_ack_i in IDLE and GAP.
REQ-023 Latency: a push to an empty FIFO at edge N SHALL give wbm_stb_o high after edge N+1.
REQ-024 A push and a pop in the same cycle SHALL leave the occupancy unchanged and SHALL be legal when full or when one entry remains.
REQ-025 Deasserting trace_en SHALL NOT flush the FIFO or abort a cycle in progress.

Reset
REQ-026 Asserting wb_rst_ low SHALL immediately force the FSM to IDLE, the pointers to 0, and drop_cnt to 0.
REQ-027 During reset, wbm_stb_o, wbm_cyc_o and wbm_we_o SHALL be 0, wbm_dat_o SHALL be 20'h0, and fifo_empty SHALL be 1.
REQ-028 Reset asserted mid-REQ SHALL drop stb/cyc asynchronously and lose the in-flight entry.
REQ-029 FIFO storage SHALL NOT require reset.

Configuration
REQ-030 Macro TRACE_DEDUP_EN: when defined, a capture whose address equals the last pushed address SHALL be silently ignored (no push, no drop count).
REQ-031 The last-pushed register SHALL be cleared by reset, with a valid flag so that a first capture of 20'h0 is pushed.
REQ-032 When TRACE_DEDUP_EN is not defined, every enabled strobe SHALL be pushed or counted as a drop, and no compare logic SHALL exist.

Verification
REQ-033 Single strobe of 20'hABCDE into an idle block -> stb high 2 edges later, wbm_dat_o=20'hABCDE; ack after 60 cycles -> one GAP cycle, FIFO empty.
REQ-034 Strobe 16 distinct addresses with ack withheld, then 3 more -> drop_cnt=3; then ack each cycle when offered -> 16 words out in push order, with a GAP between each.
REQ-035 Full FIFO, strobe on the same cycle as ack -> new address accepted, drop_cnt unchanged, occupancy stays 16.
REQ-036 Drive 300 strobes while full -> drop_cnt saturates at 8'hFF.
REQ-037 Pull wb_rst_ low mid-REQ between edges -> stb/cyc low before the next edge, fifo_empty=1, drop_cnt=0.
REQ-038 With TRACE_DEDUP_EN, strobe 20'h00100 twice then 20'h00104 -> exactly two words emitted; without the macro -> three words emitted.
